// File: rtl/mouse_master_sm_pkg.sv
// rtl/mouse_master_sm_pkg.sv - state encodings, PS/2 command bytes and receiver error codes
package mouse_master_sm_pkg;

    localparam logic [3:0] ST_RESET_SEND      = 4'd0;
    localparam logic [3:0] ST_WAIT_SENT       = 4'd1;
    localparam logic [3:0] ST_WAIT_FA         = 4'd2;
    localparam logic [3:0] ST_WAIT_AA         = 4'd3;
    localparam logic [3:0] ST_WAIT_00         = 4'd4;
    localparam logic [3:0] ST_SEND_CMD        = 4'd5;
    localparam logic [3:0] ST_WAIT_CMD_SENT   = 4'd6;
    localparam logic [3:0] ST_WAIT_CMD_ACK    = 4'd7;
    localparam logic [3:0] ST_WAIT_DEVID      = 4'd8;
    localparam logic [3:0] ST_READ_STATUS     = 4'd9;
    localparam logic [3:0] ST_READ_DX         = 4'd10;
    localparam logic [3:0] ST_READ_DY         = 4'd11;
    localparam logic [3:0] ST_READ_DZ         = 4'd12;
    localparam logic [3:0] ST_PUBLISH         = 4'd13;

    localparam logic [7:0] CMD_RESET          = 8'hFF;
    localparam logic [7:0] CMD_ENABLE         = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE       = 8'hF3;
    localparam logic [7:0] CMD_GET_ID         = 8'hF2;
    localparam logic [7:0] RSP_ACK            = 8'hFA;
    localparam logic [7:0] RSP_SELF_TEST_OK   = 8'hAA;
    localparam logic [7:0] RSP_DEVICE_ID_STD  = 8'h00;
    localparam logic [7:0] RSP_WHEEL_ID       = 8'h03;

    // The 200/100/80 sample-rate knock sequence unlocks IntelliMouse mode
    localparam logic [7:0] RATE_200           = 8'hC8;
    localparam logic [7:0] RATE_100           = 8'h64;
    localparam logic [7:0] RATE_80            = 8'h50;

    localparam logic [2:0] IDX_GET_ID         = 3'd6;
    localparam logic [2:0] IDX_ENABLE         = 3'd7;

    localparam logic [1:0] ERR_NONE           = 2'b00;
    localparam logic [1:0] ERR_PARITY         = 2'b01;
    localparam logic [1:0] ERR_FRAME          = 2'b10;

    function automatic logic is_read_state(input logic [3:0] s);
        case (s)
            ST_WAIT_FA, ST_WAIT_AA, ST_WAIT_00, ST_WAIT_CMD_ACK, ST_WAIT_DEVID,
            ST_READ_STATUS, ST_READ_DX, ST_READ_DY, ST_READ_DZ: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mouse_timeout_counter.sv
// rtl/mouse_timeout_counter.sv - per-state wait counter that saturates at TIMEOUT_CYCLES
module mouse_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic          expired,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    assign expired = (count == LIMIT);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mouse_master_sm.sv
// rtl/mouse_master_sm.sv - PS/2 mouse host FSM: reset, wheel negotiation, packet assembly
module mouse_master_sm
    import mouse_master_sm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int INIT_DELAY     = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic [7:0] MOUSE_DZ,
    output logic       SEND_INTERRUPT
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] INIT_DELAY_C =
        CW'((INIT_DELAY > TIMEOUT_CYCLES) ? TIMEOUT_CYCLES : INIT_DELAY);

    logic [3:0]    current_state;
    logic [3:0]    next_state;
    logic [2:0]    cmd_idx;
    logic          wheel;
    logic [7:0]    status_sh;
    logic [7:0]    dx_sh;
    logic [7:0]    dy_sh;
    logic [7:0]    dz_sh;
    logic [CW-1:0] tmo_count;
    logic          tmo_expired;
    logic          rx_ok;
    logic          rx_ack;
    logic          delay_done;

    function automatic logic [7:0] cmd_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return CMD_SET_RATE;
            3'd1:    return RATE_200;
            3'd2:    return CMD_SET_RATE;
            3'd3:    return RATE_100;
            3'd4:    return CMD_SET_RATE;
            3'd5:    return RATE_80;
            3'd6:    return CMD_GET_ID;
            default: return CMD_ENABLE;
        endcase
    endfunction

    assign rx_ok  = BYTE_READY && (BYTE_ERROR_CODE == ERR_NONE);
    assign rx_ack = rx_ok && (BYTE_READ == RSP_ACK);
    // Count restarts on entry to RESET_SEND, so equality fires exactly once
    assign delay_done = (tmo_count == INIT_DELAY_C);

    mouse_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CW            (CW)
    ) u_timeout (
        .clk    (CLK),
        .reset  (RESET),
        .clear  (next_state != current_state),
        .enable ((current_state != ST_READ_STATUS) && (current_state != ST_PUBLISH)),
        .expired(tmo_expired),
        .count  (tmo_count)
    );

    always_comb begin
        next_state = current_state;
        case (current_state)
            ST_RESET_SEND:    if (delay_done) next_state = ST_WAIT_SENT;
            ST_WAIT_SENT:     if (BYTE_SENT) next_state = ST_WAIT_FA;
                              else if (tmo_expired) next_state = ST_RESET_SEND;
            ST_WAIT_FA:       if (BYTE_READY) next_state = rx_ack ? ST_WAIT_AA : ST_RESET_SEND;
                              else if (tmo_expired) next_state = ST_RESET_SEND;
            ST_WAIT_AA:       if (BYTE_READY) next_state = (rx_ok && BYTE_READ == RSP_SELF_TEST_OK)
                                                           ? ST_WAIT_00 : ST_RESET_SEND;
                              else if (tmo_expired) next_state = ST_RESET_SEND;
            ST_WAIT_00:       if (BYTE_READY) next_state = (rx_ok && BYTE_READ == RSP_DEVICE_ID_STD)
                                                           ? ST_SEND_CMD : ST_RESET_SEND;
                              else if (tmo_expired) next_state = ST_RESET_SEND;
            ST_SEND_CMD:      next_state = ST_WAIT_CMD_SENT;
            ST_WAIT_CMD_SENT: if (BYTE_SENT) next_state = ST_WAIT_CMD_ACK;
                              else if (tmo_expired) next_state = ST_RESET_SEND;
            ST_WAIT_CMD_ACK: begin
                if (BYTE_READY) begin
                    if (!rx_ack)                   next_state = ST_RESET_SEND;
                    else if (cmd_idx == IDX_GET_ID) next_state = ST_WAIT_DEVID;
                    else if (cmd_idx == IDX_ENABLE) next_state = ST_READ_STATUS;
                    else                           next_state = ST_SEND_CMD;
                end else if (tmo_expired) begin
                    next_state = ST_RESET_SEND;
                end
            end
            // Any clean device-ID byte continues; only its value decides wheel mode
            ST_WAIT_DEVID:    if (BYTE_READY) next_state = rx_ok ? ST_SEND_CMD : ST_RESET_SEND;
                              else if (tmo_expired) next_state = ST_RESET_SEND;
            ST_READ_STATUS:   if (rx_ok && BYTE_READ[3]) next_state = ST_READ_DX;
            ST_READ_DX:       if (BYTE_READY) next_state = rx_ok ? ST_READ_DY : ST_READ_STATUS;
                              else if (tmo_expired) next_state = ST_READ_STATUS;
            ST_READ_DY:       if (BYTE_READY) next_state = !rx_ok ? ST_READ_STATUS
                                                         : (wheel ? ST_READ_DZ : ST_PUBLISH);
                              else if (tmo_expired) next_state = ST_READ_STATUS;
            ST_READ_DZ:       if (BYTE_READY) next_state = rx_ok ? ST_PUBLISH : ST_READ_STATUS;
                              else if (tmo_expired) next_state = ST_READ_STATUS;
            ST_PUBLISH:       next_state = ST_READ_STATUS;
            default:          next_state = ST_RESET_SEND;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            current_state  <= ST_RESET_SEND;
            cmd_idx        <= '0;
            wheel          <= 1'b0;
            status_sh      <= '0;
            dx_sh          <= '0;
            dy_sh          <= '0;
            dz_sh          <= '0;
            SEND_BYTE      <= 1'b0;
            BYTE_TO_SEND   <= '0;
            READ_ENABLE    <= 1'b0;
            MOUSE_STATUS   <= '0;
            MOUSE_DX       <= '0;
            MOUSE_DY       <= '0;
            MOUSE_DZ       <= '0;
            SEND_INTERRUPT <= 1'b0;
        end else begin
            current_state  <= next_state;
            SEND_BYTE      <= 1'b0;
            SEND_INTERRUPT <= 1'b0;
            READ_ENABLE    <= is_read_state(next_state);
            case (current_state)
                ST_RESET_SEND: begin
                    cmd_idx <= '0;
                    wheel   <= 1'b0;
                    if (delay_done) begin
                        SEND_BYTE    <= 1'b1;
                        BYTE_TO_SEND <= CMD_RESET;
                    end
                end
                ST_SEND_CMD: begin
                    SEND_BYTE    <= 1'b1;
                    BYTE_TO_SEND <= cmd_rom(cmd_idx);
                end
                ST_WAIT_CMD_ACK: if (rx_ack) cmd_idx <= cmd_idx + 3'd1;
                ST_WAIT_DEVID:   if (rx_ok) wheel <= (BYTE_READ == RSP_WHEEL_ID);
                ST_READ_STATUS:  if (rx_ok && BYTE_READ[3]) status_sh <= BYTE_READ;
                ST_READ_DX:      if (rx_ok) dx_sh <= BYTE_READ;
                ST_READ_DY:      if (rx_ok) dy_sh <= BYTE_READ;
                ST_READ_DZ:      if (rx_ok) dz_sh <= BYTE_READ;
                ST_PUBLISH: begin
                    MOUSE_STATUS   <= status_sh;
                    MOUSE_DX       <= dx_sh;
                    MOUSE_DY       <= dy_sh;
                    MOUSE_DZ       <= wheel ? dz_sh : 8'h00;
                    SEND_INTERRUPT <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_master_sm.sv
// tb/tb_mouse_master_sm.sv - randomized self-checking bench with a packet-level mouse model
module tb_mouse_master_sm;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT = 1'b0;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ = 8'h00;
    logic [1:0] BYTE_ERROR_CODE = 2'b00;
    logic       BYTE_READY = 1'b0;
    logic [7:0] MOUSE_STATUS;
    logic [7:0] MOUSE_DX;
    logic [7:0] MOUSE_DY;
    logic [7:0] MOUSE_DZ;
    logic       SEND_INTERRUPT;

    int tests = 0;
    int fails = 0;
    int irq_seen = 0;
    int irq_wide = 0;
    int overlap = 0;
    logic irq_prev = 1'b0;

    logic [7:0] exp_status = 8'h00;
    logic [7:0] exp_dx = 8'h00;
    logic [7:0] exp_dy = 8'h00;
    logic [7:0] exp_dz = 8'h00;
    int         exp_irq = 0;
    bit         exp_wheel = 1'b0;
    logic [7:0] cmd_list [8] = '{8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};

    mouse_master_sm #(
        .TIMEOUT_CYCLES(100),
        .INIT_DELAY    (0)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .SEND_BYTE      (SEND_BYTE),
        .BYTE_TO_SEND   (BYTE_TO_SEND),
        .BYTE_SENT      (BYTE_SENT),
        .READ_ENABLE    (READ_ENABLE),
        .BYTE_READ      (BYTE_READ),
        .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
        .BYTE_READY     (BYTE_READY),
        .MOUSE_STATUS   (MOUSE_STATUS),
        .MOUSE_DX       (MOUSE_DX),
        .MOUSE_DY       (MOUSE_DY),
        .MOUSE_DZ       (MOUSE_DZ),
        .SEND_INTERRUPT (SEND_INTERRUPT)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (SEND_INTERRUPT) irq_seen++;
        if (SEND_INTERRUPT && irq_prev) irq_wide++;
        if (SEND_BYTE && READ_ENABLE) overlap++;
        irq_prev = SEND_INTERRUPT;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_send(output bit seen, output int cycles);
        seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < 200) begin
            @(negedge CLK);
            cycles++;
            if (SEND_BYTE) seen = 1'b1;
        end
    endtask

    task automatic ack_send(input logic [7:0] exp_byte);
        tick($urandom_range(0, 3));
        check("cmd_held", BYTE_TO_SEND, exp_byte);
        BYTE_SENT = 1'b1;
        @(negedge CLK);
        BYTE_SENT = 1'b0;
    endtask

    task automatic expect_cmd(input logic [7:0] exp_byte);
        bit seen;
        int cyc;
        wait_send(seen, cyc);
        check("send_seen", seen, 1);
        check("cmd_byte", BYTE_TO_SEND, exp_byte);
        check("no_rd_en_on_send", READ_ENABLE, 0);
        ack_send(exp_byte);
    endtask

    task automatic rx(input logic [7:0] data, input logic [1:0] err);
        int cnt;
        tick($urandom_range(0, 3));
        cnt = 0;
        while (!READ_ENABLE && cnt < 200) begin
            @(negedge CLK);
            cnt++;
        end
        if (!READ_ENABLE) check("rx_wait_rd_en", READ_ENABLE, 1);
        BYTE_READ = data;
        BYTE_ERROR_CODE = err;
        BYTE_READY = 1'b1;
        @(negedge CLK);
        BYTE_READY = 1'b0;
        BYTE_ERROR_CODE = 2'b00;
        BYTE_READ = 8'($urandom);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_status"}, MOUSE_STATUS, exp_status);
        check({tag, "_dx"}, MOUSE_DX, exp_dx);
        check({tag, "_dy"}, MOUSE_DY, exp_dy);
        check({tag, "_dz"}, MOUSE_DZ, exp_dz);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        BYTE_SENT = 1'b0;
        BYTE_READY = 1'b0;
        tick(5);
        exp_status = 8'h00; exp_dx = 8'h00; exp_dy = 8'h00; exp_dz = 8'h00;
        exp_wheel = 1'b0;
        check_outputs("rst");
        check("rst_send", SEND_BYTE, 0);
        check("rst_rd_en", READ_ENABLE, 0);
        check("rst_irq", SEND_INTERRUPT, 0);
        check("rst_state", dut.current_state, 0);
        RESET = 1'b0;
        @(negedge CLK);
        check("first_send", SEND_BYTE, 1);
        check("first_byte", BYTE_TO_SEND, 8'hFF);
    endtask

    task automatic do_init(input logic [7:0] id_answer);
        rx(8'hFA, 2'b00);
        rx(8'hAA, 2'b00);
        rx(8'h00, 2'b00);
        for (int i = 0; i < 8; i++) begin
            expect_cmd(cmd_list[i]);
            rx(8'hFA, 2'b00);
            if (cmd_list[i] == 8'hF2) rx(id_answer, 2'b00);
        end
        exp_wheel = (id_answer == 8'h03);
        tick(1);
        check("init_state", dut.current_state, 9);
        check("init_rd_en", READ_ENABLE, 1);
    endtask

    // err_pos < 0: clean packet; otherwise that byte carries err_code and the packet is lost
    task automatic packet(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy,
                          input logic [7:0] dz, input int err_pos, input logic [1:0] err_code);
        logic [7:0] b [4];
        int  nbytes;
        bit  aborted;
        b[0] = st; b[1] = dx; b[2] = dy; b[3] = dz;
        nbytes = exp_wheel ? 4 : 3;
        aborted = 1'b0;
        for (int i = 0; i < nbytes && !aborted; i++) begin
            if (i == err_pos) begin
                rx(b[i], err_code);
                aborted = 1'b1;
            end else begin
                rx(b[i], 2'b00);
            end
        end
        if (!aborted) begin
            exp_status = st; exp_dx = dx; exp_dy = dy;
            exp_dz = exp_wheel ? dz : 8'h00;
            exp_irq++;
        end
        tick(4);
        check("irq_count", irq_seen, exp_irq);
        check("irq_width", irq_wide, 0);
        check_outputs("pkt");
        check("pkt_state", dut.current_state, 9);
    endtask

    task automatic random_packets(input int n);
        logic [7:0] st;
        logic [1:0] code;
        int pos;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) rx(8'($urandom) & 8'hF7, 2'b00);
            st = 8'($urandom) | 8'h08;
            pos = -1;
            code = 2'b00;
            if ($urandom_range(0, 3) == 0) begin
                pos = $urandom_range(1, exp_wheel ? 3 : 2);
                code = 2'($urandom_range(1, 3));
            end
            packet(st, 8'($urandom), 8'($urandom), 8'($urandom), pos, code);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        int cyc;
        tick(1);
        do_reset();
        ack_send(8'hFF);

        rx(8'hFA, 2'b00);
        rx(8'hAA, 2'b01);
        check("aa_err_state", dut.current_state, 0);
        expect_cmd(8'hFF);
        do_init(8'h03);

        packet(8'h08, 8'h05, 8'hFB, 8'h01, -1, 2'b00);

        rx(8'h00, 2'b00);
        tick(2);
        check("resync_state", dut.current_state, 9);
        check("resync_irq", irq_seen, exp_irq);

        packet(8'h0A, 8'h11, 8'h22, 8'h33, 1, 2'b10);
        random_packets(10);

        rx(8'h18, 2'b00);
        rx(8'h07, 2'b00);
        do_reset();
        ack_send(8'hFF);
        do_init(8'h00);
        packet(8'h09, 8'h10, 8'h20, 8'h55, -1, 2'b00);
        random_packets(6);

        do_reset();
        tick(50);
        check("tmo_still_waiting", dut.current_state, 1);
        wait_send(seen, cyc);
        check("tmo_resend_seen", seen, 1);
        check("tmo_window", ((cyc + 50) >= 100) && ((cyc + 50) <= 104), 1);
        check("tmo_resend_byte", BYTE_TO_SEND, 8'hFF);

        check("send_rd_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
